// File: rtl/pad_ctrl_bank.sv
// pad_ctrl_bank: per-pad control registers (shadow/active pairs with atomic
// apply) driving gf180mcu bidir pad controls, plus per-pad input
// synchronisation, debounce and rise/fall pulse generation.
//
// Config port: cfg_we / cfg_re / cfg_apply are single-cycle strobes sampled on
// the rising clock edge; there is no back-pressure, every strobe is accepted
// in the cycle it is seen. Read data appears on cfg_rdata the cycle after
// cfg_re and holds until the next read.
module pad_ctrl_bank #(
    parameter int  NUM_CH      = 40,
    parameter int  SYNC_STAGES = 2,
    parameter int  DEB_CYCLES  = 4,
    localparam int AW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [7:0]        cfg_wdata,
    input  logic              cfg_apply,
    output logic [7:0]        cfg_rdata,
    output logic              cfg_err,
    output logic              cfg_pending,
    input  logic [NUM_CH-1:0] core_out,
    input  logic [NUM_CH-1:0] pad_y,
    output logic [NUM_CH-1:0] pad_a,
    output logic [NUM_CH-1:0] pad_oe,
    output logic [NUM_CH-1:0] pad_ie,
    output logic [NUM_CH-1:0] pad_pu,
    output logic [NUM_CH-1:0] pad_pd,
    output logic [NUM_CH-1:0] pad_cs,
    output logic [NUM_CH-1:0] pad_sl,
    output logic [NUM_CH-1:0] in_level,
    output logic [NUM_CH-1:0] in_rise,
    output logic [NUM_CH-1:0] in_fall
);

    // Control byte layout
    localparam int B_OE      = 0;
    localparam int B_OUT_SRC = 1;
    localparam int B_OUT_LVL = 2;
    localparam int B_IE      = 3;
    localparam int B_PU      = 4;
    localparam int B_PD      = 5;
    localparam int B_CS      = 6;
    localparam int B_SL      = 7;

    localparam logic [7:0] CTRL_RST = 8'h08;

    logic [7:0] shadow_q [NUM_CH];
    logic [7:0] active_q [NUM_CH];
    logic [7:0] shadow_d [NUM_CH];
    logic [7:0] active_d [NUM_CH];
    logic       pending_d;
    logic       addr_ok;
    logic       wr_ok;

    assign addr_ok = (32'(cfg_addr) < NUM_CH);
    assign wr_ok   = cfg_we & addr_ok;

    // Next register state; apply copies the post-write shadow so a
    // concurrent write is forwarded into the active register.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = 1'b0;
        if (wr_ok) begin
            shadow_d[cfg_addr] = cfg_wdata;
        end
        if (cfg_apply) begin
            active_d = shadow_d;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (shadow_d[i] != active_d[i]) begin
                pending_d = 1'b1;
            end
        end
    end

    // Shadow/active register file and pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= CTRL_RST;
                active_q[i] <= CTRL_RST;
            end
            cfg_pending <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            cfg_pending <= pending_d;
        end
    end

    // Registered read port and out-of-range error pulse; reads see the
    // shadow value from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata <= 8'h00;
            cfg_err   <= 1'b0;
        end else begin
            if (cfg_re) begin
                cfg_rdata <= addr_ok ? shadow_q[cfg_addr] : 8'h00;
            end
            cfg_err <= (cfg_we | cfg_re) & ~addr_ok;
        end
    end

    // Pad controls decode straight from the active registers; PU wins over PD.
    always_comb begin
        pad_a  = '0;
        pad_oe = '0;
        pad_ie = '0;
        pad_pu = '0;
        pad_pd = '0;
        pad_cs = '0;
        pad_sl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pad_oe[i] = active_q[i][B_OE];
            pad_ie[i] = active_q[i][B_IE];
            pad_pu[i] = active_q[i][B_PU];
            pad_pd[i] = active_q[i][B_PD] & ~active_q[i][B_PU];
            pad_cs[i] = active_q[i][B_CS];
            pad_sl[i] = active_q[i][B_SL];
            pad_a[i]  = active_q[i][B_OUT_SRC] ? core_out[i] : active_q[i][B_OUT_LVL];
        end
    end

    // Per-channel input conditioning
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   level_q;
        logic                   prev_q;
        logic                   rise_q;
        logic                   fall_q;

        assign s = sync_q[SYNC_STAGES-1];

        // Synchroniser chain for the asynchronous pad Y
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pad_y[g]};
            end
        end

        if (DEB_CYCLES == 0) begin : g_bypass
            // Debounce bypassed: level follows the synchronised input
            always_ff @(posedge clk) begin
                if (rst) begin
                    level_q <= 1'b0;
                end else begin
                    level_q <= s;
                end
            end
        end else begin : g_deb
            localparam int CW = $clog2(DEB_CYCLES + 1);
            logic [CW-1:0] cnt_q;

            // Accept a new level after DEB_CYCLES consecutive disagreeing samples
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end else if (s == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    level_q <= s;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        // Registered edge detect of the debounced level
        always_ff @(posedge clk) begin
            if (rst) begin
                prev_q <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                prev_q <= level_q;
                rise_q <= level_q & ~prev_q;
                fall_q <= ~level_q & prev_q;
            end
        end

        assign in_level[g] = level_q;
        assign in_rise[g]  = rise_q;
        assign in_fall[g]  = fall_q;
    end

endmodule

// File: tb/tb_pad_ctrl_bank.sv
// Directed testbench for pad_ctrl_bank with NUM_CH=40, SYNC_STAGES=2,
// DEB_CYCLES=4: a table of single-cycle config vectors followed by
// hand-written sequences for core_out muxing, reset and the input path.
module tb_pad_ctrl_bank;

    localparam int NUM_CH = 40;
    localparam int AW     = 6;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic              cfg_re;
    logic [AW-1:0]     cfg_addr;
    logic [7:0]        cfg_wdata;
    logic              cfg_apply;
    logic [7:0]        cfg_rdata;
    logic              cfg_err;
    logic              cfg_pending;
    logic [NUM_CH-1:0] core_out;
    logic [NUM_CH-1:0] pad_y;
    logic [NUM_CH-1:0] pad_a;
    logic [NUM_CH-1:0] pad_oe;
    logic [NUM_CH-1:0] pad_ie;
    logic [NUM_CH-1:0] pad_pu;
    logic [NUM_CH-1:0] pad_pd;
    logic [NUM_CH-1:0] pad_cs;
    logic [NUM_CH-1:0] pad_sl;
    logic [NUM_CH-1:0] in_level;
    logic [NUM_CH-1:0] in_rise;
    logic [NUM_CH-1:0] in_fall;

    int errors = 0;
    int checks = 0;

    pad_ctrl_bank #(
        .NUM_CH(NUM_CH),
        .SYNC_STAGES(2),
        .DEB_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_apply(cfg_apply),
        .cfg_rdata(cfg_rdata), .cfg_err(cfg_err), .cfg_pending(cfg_pending),
        .core_out(core_out), .pad_y(pad_y),
        .pad_a(pad_a), .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_pu(pad_pu),
        .pad_pd(pad_pd), .pad_cs(pad_cs), .pad_sl(pad_sl),
        .in_level(in_level), .in_rise(in_rise), .in_fall(in_fall)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One config vector: strobes for one cycle, then expected state after the edge.
    // pads = {sl, cs, pd, pu, ie, oe, a} of channel ch.
    typedef struct {
        logic       we;
        logic       re;
        logic       ap;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
        logic       pend;
        int         ch;
        logic [6:0] pads;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        cfg_apply = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
    endtask

    function automatic logic [6:0] pads_of(input int ch);
        return {pad_sl[ch], pad_cs[ch], pad_pd[ch], pad_pu[ch], pad_ie[ch], pad_oe[ch], pad_a[ch]};
    endfunction

    initial begin
        //        we    re    ap    addr   wdata  rdata  err   pend  ch  pads
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 0, 7'h04};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 6'd0,  8'h00, 8'h08, 1'b0, 1'b0, 0, 7'h04};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'd3,  8'h05, 8'h08, 1'b0, 1'b1, 3, 7'h04};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 6'd0,  8'h00, 8'h08, 1'b0, 1'b0, 3, 7'h03};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'd3,  8'h00, 8'h05, 1'b0, 1'b0, 3, 7'h03};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 6'd7,  8'h38, 8'h05, 1'b0, 1'b1, 7, 7'h04};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 6'd0,  8'h00, 8'h05, 1'b0, 1'b0, 7, 7'h0C};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 6'd7,  8'h00, 8'h38, 1'b0, 1'b0, 7, 7'h0C};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'd40, 8'h00, 8'h00, 1'b1, 1'b0, 7, 7'h0C};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 0, 7'h04};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 6'd40, 8'hFF, 8'h00, 1'b1, 1'b0, 0, 7'h04};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 6'd0,  8'h00, 8'h08, 1'b0, 1'b0, 0, 7'h04};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 6'd63, 8'h00, 8'h00, 1'b1, 1'b0, 0, 7'h04};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 6'd3,  8'hAA, 8'h05, 1'b0, 1'b1, 3, 7'h03};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 6'd3,  8'h00, 8'hAA, 1'b0, 1'b1, 3, 7'h03};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 6'd5,  8'h03, 8'hAA, 1'b0, 1'b0, 5, 7'h02};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 6'd0,  8'h00, 8'hAA, 1'b0, 1'b0, 3, 7'h54};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 6'd40, 8'h00, 8'h00, 1'b1, 1'b0, 3, 7'h54};

        // Reset
        rst      = 1'b1;
        core_out = '0;
        pad_y    = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_ie",      64'(pad_ie), {24'h0, {NUM_CH{1'b1}}});
        check("rst_oe",      64'(pad_oe), 64'h0);
        check("rst_a",       64'(pad_a), 64'h0);
        check("rst_pu",      64'(pad_pu), 64'h0);
        check("rst_pd",      64'(pad_pd), 64'h0);
        check("rst_pending", 64'(cfg_pending), 64'h0);
        check("rst_rdata",   64'(cfg_rdata), 64'h0);
        check("rst_level",   64'(in_level), 64'h0);

        // Config vector table
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            cfg_we    = vecs[v].we;
            cfg_re    = vecs[v].re;
            cfg_apply = vecs[v].ap;
            cfg_addr  = vecs[v].addr;
            cfg_wdata = vecs[v].wdata;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rdata", v), 64'(cfg_rdata), 64'(vecs[v].rdata));
            check($sformatf("v%0d_err", v), 64'(cfg_err), 64'(vecs[v].err));
            check($sformatf("v%0d_pending", v), 64'(cfg_pending), 64'(vecs[v].pend));
            check($sformatf("v%0d_pads_ch%0d", v, vecs[v].ch), 64'(pads_of(vecs[v].ch)), 64'(vecs[v].pads));
        end
        @(negedge clk);
        idle_inputs();

        // OUT_SRC=1 channels follow core_out combinationally
        core_out[5] = 1'b1;
        #1 check("core5_hi", 64'(pad_a[5]), 64'h1);
        core_out[5] = 1'b0;
        #1 check("core5_lo", 64'(pad_a[5]), 64'h0);
        core_out[3] = 1'b1;
        #1 check("core3_hi", 64'(pad_a[3]), 64'h1);
        check("core7_unaffected", 64'(pad_a[7]), 64'h0);
        core_out = '0;

        // Reset wins over concurrent write and apply
        @(negedge clk);
        rst       = 1'b1;
        cfg_we    = 1'b1;
        cfg_apply = 1'b1;
        cfg_addr  = 6'd0;
        cfg_wdata = 8'hFF;
        @(posedge clk);
        #1;
        check("midrst_pending", 64'(cfg_pending), 64'h0);
        check("midrst_rdata",   64'(cfg_rdata), 64'h0);
        check("midrst_oe",      64'(pad_oe), 64'h0);
        check("midrst_ie",      64'(pad_ie), {24'h0, {NUM_CH{1'b1}}});
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        cfg_re = 1'b1;
        @(posedge clk);
        #1 check("midrst_read0", 64'(cfg_rdata), 64'h08);
        @(negedge clk);
        idle_inputs();

        // ch0 rising edge held: level after edge 6, rise pulse after edge 7
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            pad_y[0] = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("rise_lvl_e%0d", e), 64'(in_level[0]), 64'(e >= 6));
            check($sformatf("rise_pulse_e%0d", e), 64'(in_rise[0]), 64'(e == 7));
            check($sformatf("rise_nofall_e%0d", e), 64'(in_fall[0]), 64'h0);
        end

        // ch0 falling edge held
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            pad_y[0] = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("fall_lvl_e%0d", e), 64'(in_level[0]), 64'(e < 6));
            check($sformatf("fall_pulse_e%0d", e), 64'(in_fall[0]), 64'(e == 7));
        end

        // ch1 3-cycle glitch rejected; ch2 4-cycle pulse accepted
        for (int e = 1; e <= 13; e++) begin
            @(negedge clk);
            pad_y[1] = (e <= 3);
            pad_y[2] = (e <= 4);
            @(posedge clk);
            #1;
            check($sformatf("glitch_lvl_e%0d", e), 64'(in_level[1]), 64'h0);
            check($sformatf("glitch_edges_e%0d", e), 64'({in_rise[1], in_fall[1]}), 64'h0);
            check($sformatf("pulse4_lvl_e%0d", e), 64'(in_level[2]), 64'(e >= 6 && e <= 9));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
